fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Instruction-fetch controller that drives the program counter's next-value input (pc_in) and consumes its registered output (pc_out). It issues req/ack reads to instruction memory and presents fetched instructions to decode over a valid/ready interface. It buffers up to two instructions and handles branch/jump redirects, including flushing a read that is still in flight. The pc register loads pc_in on every clk edge and has no enable, so fetch_ctrl must drive pc_in = pc_out to hold the PC.

Parameters:
ADDR_W, 10, PC / instruction-memory address width
INSTR_W, 16, instruction word width
RESET_VECTOR, 0, PC value loaded during reset

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
pc_out  input  ADDR_W  current PC from pc register
pc_in  output  ADDR_W  next PC, loaded by pc register every edge
imem_req  output  1  memory read request, level
imem_addr  output  ADDR_W  read address, stable while imem_req high
imem_ack  input  1  one-cycle pulse; imem_data valid this cycle; may come in the same cycle as req
imem_data  input  INSTR_W  read data
redirect  input  1  branch/jump taken, one-cycle pulse
redirect_target  input  ADDR_W  new PC
instr  output  INSTR_W  fetched instruction
instr_pc  output  ADDR_W  address of instr
instr_valid  output  1  instr/instr_pc valid
instr_ready  input  1  decode accepts; transfer = valid & ready

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high.
- While reset is high:
  - pc_in = RESET_VECTOR (combinational).
  - imem_req = 0.
  - Registered state: state<=FETCH, instr_valid<=0, instr<=0, instr_pc<=0, skid_valid<=0.
  - Reset mid-transaction abandons any outstanding read. Instruction memory shares the same reset, so no stray ack follows.
- States: FETCH, STALL, FLUSH.
- FETCH:
  - imem_req=1, imem_addr=pc_out; req_addr<=pc_out each cycle.
  - No ack: pc_in=pc_out (hold).
  - Ack and output slot free (!instr_valid | instr_ready): instr<=imem_data, instr_pc<=pc_out, instr_valid<=1, pc_in=pc_out+1, stay FETCH. Sustains one instruction per cycle with zero-wait memory.
  - Ack and slot full (instr_valid & !instr_ready): skid<=data/pc, skid_valid<=1, pc_in=pc_out+1, go to STALL.
- STALL:
  - imem_req=0, pc_in=pc_out.
  - On instr_ready: output<=skid, skid_valid<=0, go to FETCH.
- FLUSH:
  - imem_req=1, imem_addr=req_addr (old address held stable), pc_in=pc_out.
  - On ack: data discarded, go to FETCH.
- Redirect (highest priority, any state):
  - pc_in=redirect_target.
  - instr_valid<=0 and skid_valid<=0 next cycle; a decode transfer in the redirect cycle still completes.
  - Next state:
    - FETCH without ack → FLUSH.
    - FETCH with ack in the same cycle → data dropped, stay FETCH.
    - STALL → FETCH.
    - FLUSH → stays FLUSH.
- PC arithmetic: pc_out+1 modulo 2^ADDR_W, so 0x3FF wraps to 0x000. No overflow flag.
- Ordering: instructions reach decode in fetch order, with no duplication or loss outside redirect flushes.
- Invariant: skid_valid implies instr_valid.

Decomposition:
- Shared package/header fetch_pkg holds:
  - state encoding constants FETCH, STALL, FLUSH (2-bit)
  - default ADDR_W, INSTR_W, RESET_VECTOR
- Natural sub-module: fetch_skid_buf, a 2-entry output register plus skid register with valid/ready.
- The FSM and PC-next mux stay in fetch_ctrl.

Test Plan:
- Reset: hold reset 2 cycles → pc_in=0, imem_req=0, instr_valid=0. Release → pc_out=0, imem_req=1, imem_addr=0.
- Streaming: zero-wait ack every cycle, imem_data=0x100+addr, instr_ready=1 → instr 0x100, 0x101, 0x102 with instr_pc 0, 1, 2 on consecutive cycles.
- Backpressure: instr_ready=0 after the first instr; ack at pc=1 → STALL, imem_req=0, pc held at 2. Raise instr_ready → instr_pc 1 delivered once, then fetch resumes at 2 with no loss or duplication.
- Redirect in flight: ack delayed 3 cycles; redirect to 0x200 at cycle 1 → imem_addr held at the old value until ack, that data is never presented, next req at 0x200, first instr_pc=0x200.
- Simultaneous events: redirect in the same cycle as ack → data dropped, next imem_addr=target. Also pc_out=0x3FF with ack → pc_in=0x000.
- Reset in STALL with skid full → next cycle instr_valid=0, skid cleared, pc_out=RESET_VECTOR.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch controller.
package fetch_pkg;

    localparam int unsigned ADDR_W_DEF       = 10;
    localparam int unsigned INSTR_W_DEF      = 16;
    localparam int unsigned RESET_VECTOR_DEF = 0;

    // Fetch FSM state encoding
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry output stage: the decode-facing register plus a skid register
// that catches one instruction arriving while decode is back-pressuring.
module fetch_skid_buf
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic [ADDR_W-1:0]  push_pc,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    output logic               skid_valid
);

    logic [INSTR_W-1:0] skid_instr;
    logic [ADDR_W-1:0]  skid_pc;

    // Output/skid registers; flush wins over everything but reset, and a
    // transfer that coincides with the flush has already completed at decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            skid_instr  <= '0;
            skid_pc     <= '0;
            skid_valid  <= 1'b0;
        end else if (flush) begin
            instr_valid <= 1'b0;
            skid_valid  <= 1'b0;
        end else if (skid_valid) begin
            // Output slot is full while skid holds data; drain skid on transfer
            if (instr_ready) begin
                instr      <= skid_instr;
                instr_pc   <= skid_pc;
                skid_valid <= 1'b0;
            end
        end else if (push) begin
            if (!instr_valid || instr_ready) begin
                instr       <= push_instr;
                instr_pc    <= push_pc;
                instr_valid <= 1'b1;
            end else begin
                skid_instr <= push_instr;
                skid_pc    <= push_pc;
                skid_valid <= 1'b1;
            end
        end else if (instr_ready) begin
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: drives the external PC register's next value,
// issues instruction-memory reads and hands instructions to decode.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned INSTR_W      = INSTR_W_DEF,
    parameter int unsigned RESET_VECTOR = RESET_VECTOR_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_out,
    output logic [ADDR_W-1:0]  pc_in,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready
);

    localparam logic [ADDR_W-1:0] RV = ADDR_W'(RESET_VECTOR);

    fetch_state_t       state;
    fetch_state_t       state_nxt;
    logic [ADDR_W-1:0]  req_addr;
    logic               push_c;
    logic               slot_free_c;
    logic               skid_valid;

    assign slot_free_c = !instr_valid || instr_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Remember the address of the read issued while fetching so a flushed
    // read keeps its address stable until memory acknowledges it.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_addr <= RV;
        end else if (state == FETCH) begin
            req_addr <= pc_out;
        end
    end

    // Next-state, PC-next mux and memory request
    always_comb begin
        state_nxt = state;
        pc_in     = pc_out;
        imem_req  = 1'b0;
        imem_addr = pc_out;
        push_c    = 1'b0;

        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack && !redirect) begin
                    push_c = 1'b1;
                    pc_in  = pc_out + ADDR_W'(1);
                    if (!slot_free_c) begin
                        state_nxt = STALL;
                    end
                end else if (!imem_ack && redirect) begin
                    // Read still outstanding: wait it out and drop its data
                    state_nxt = FLUSH;
                end
            end
            STALL: begin
                if (redirect || instr_ready || !skid_valid) begin
                    state_nxt = FETCH;
                end
            end
            FLUSH: begin
                imem_req  = 1'b1;
                imem_addr = req_addr;
                // An ack here retires the stale read even if another redirect
                // arrives, so there is nothing left to flush.
                if (imem_ack) begin
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase

        if (redirect) begin
            pc_in = redirect_target;
        end

        if (reset) begin
            state_nxt = FETCH;
            pc_in     = RV;
            imem_req  = 1'b0;
            push_c    = 1'b0;
        end
    end

    // Decode-facing output register with skid slot
    fetch_skid_buf #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .flush       (redirect),
        .push        (push_c),
        .push_instr  (imem_data),
        .push_pc     (pc_out),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .skid_valid  (skid_valid)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a PC register and a fixed-latency
// instruction memory returning 0x100 + address.
module tb_fetch_ctrl;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned INSTR_W = 16;

    logic               clk;
    logic               reset;
    logic [ADDR_W-1:0]  pc_out;
    logic [ADDR_W-1:0]  pc_in;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_target;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               instr_ready;

    int lat;
    int wait_cnt;
    int n_checks;
    int n_fail;

    fetch_ctrl #(
        .ADDR_W       (ADDR_W),
        .INSTR_W      (INSTR_W),
        .RESET_VECTOR (0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_out          (pc_out),
        .pc_in           (pc_in),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_data       (imem_data),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External PC register: loads pc_in every edge
    always_ff @(posedge clk) pc_out <= pc_in;

    // Memory: ack after `lat` waiting cycles of a held request
    always_comb begin
        imem_ack  = imem_req && (wait_cnt == lat);
        imem_data = INSTR_W'(16'h0100) + INSTR_W'(imem_addr);
    end

    always_ff @(posedge clk) begin
        if (reset || !imem_req || imem_ack) wait_cnt <= 0;
        else                                wait_cnt <= wait_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Two reset cycles, then release; returns in the first post-reset cycle
    task automatic reset_dut(input logic rdy, input int l);
        reset           = 1'b1;
        redirect        = 1'b0;
        redirect_target = '0;
        instr_ready     = rdy;
        lat             = l;
        cyc();
        cyc();
        reset = 1'b0;
        settle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got 0x0 expected 0x1");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset and zero-wait streaming
        reset = 1'b1; redirect = 1'b0; redirect_target = '0;
        instr_ready = 1'b1; lat = 0;
        cyc(); cyc(); settle();
        check("rst_pc_in", 32'(pc_in), 32'h0);
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        reset = 1'b0;
        settle();
        check("rel_pc_out", 32'(pc_out), 32'h0);
        check("rel_req", 32'(imem_req), 32'h1);
        check("rel_addr", 32'(imem_addr), 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("stream_instr", 32'(instr), 32'h100 + 32'(i));
            check("stream_pc", 32'(instr_pc), 32'(i));
            check("stream_valid", 32'(instr_valid), 32'h1);
        end

        // Backpressure into STALL and recovery
        reset_dut(1'b0, 0);
        cyc();
        check("bp_first_pc", 32'(instr_pc), 32'h0);
        cyc(); settle();
        check("bp_stall_req", 32'(imem_req), 32'h0);
        check("bp_stall_pc_in", 32'(pc_in), 32'h2);
        check("bp_stall_pc_out", 32'(pc_out), 32'h2);
        cyc(); settle();
        check("bp_hold_req", 32'(imem_req), 32'h0);
        check("bp_hold_out_pc", 32'(instr_pc), 32'h0);
        instr_ready = 1'b1;
        cyc(); settle();
        check("bp_skid_pc", 32'(instr_pc), 32'h1);
        check("bp_skid_instr", 32'(instr), 32'h101);
        check("bp_resume_addr", 32'(imem_addr), 32'h2);
        cyc();
        check("bp_next_pc", 32'(instr_pc), 32'h2);
        check("bp_next_instr", 32'(instr), 32'h102);
        cyc();
        check("bp_next2_pc", 32'(instr_pc), 32'h3);

        // Redirect while a 3-wait read is in flight
        reset_dut(1'b1, 3);
        cyc();
        redirect = 1'b1; redirect_target = 10'h200;
        settle();
        check("fl_pc_in", 32'(pc_in), 32'h200);
        check("fl_no_ack", 32'(imem_ack), 32'h0);
        cyc();
        redirect = 1'b0;
        settle();
        check("fl_pc_out", 32'(pc_out), 32'h200);
        check("fl_addr_held", 32'(imem_addr), 32'h0);
        check("fl_req", 32'(imem_req), 32'h1);
        cyc(); settle();
        check("fl_ack", 32'(imem_ack), 32'h1);
        check("fl_ack_addr", 32'(imem_addr), 32'h0);
        cyc();
        lat = 0;
        settle();
        check("fl_dropped", 32'(instr_valid), 32'h0);
        check("fl_new_addr", 32'(imem_addr), 32'h200);
        cyc();
        check("fl_first_pc", 32'(instr_pc), 32'h200);
        check("fl_first_instr", 32'(instr), 32'h300);

        // Redirect coinciding with ack, then PC wrap at 0x3FF
        reset_dut(1'b1, 0);
        redirect = 1'b1; redirect_target = 10'h155;
        settle();
        check("sim_pc_in", 32'(pc_in), 32'h155);
        cyc();
        redirect = 1'b0;
        settle();
        check("sim_dropped", 32'(instr_valid), 32'h0);
        check("sim_addr", 32'(imem_addr), 32'h155);
        cyc();
        check("sim_pc", 32'(instr_pc), 32'h155);
        check("sim_instr", 32'(instr), 32'h255);
        redirect = 1'b1; redirect_target = 10'h3FF;
        settle();
        cyc();
        redirect = 1'b0;
        settle();
        check("wrap_valid", 32'(instr_valid), 32'h0);
        check("wrap_pc_out", 32'(pc_out), 32'h3FF);
        check("wrap_pc_in", 32'(pc_in), 32'h0);
        cyc();
        check("wrap_instr_pc", 32'(instr_pc), 32'h3FF);
        check("wrap_instr", 32'(instr), 32'h4FF);
        settle();
        check("wrap_addr", 32'(imem_addr), 32'h0);
        cyc();
        check("wrap_next_pc", 32'(instr_pc), 32'h0);
        check("wrap_next_instr", 32'(instr), 32'h100);

        // Reset while stalled with the skid full
        reset_dut(1'b0, 0);
        cyc(); cyc(); settle();
        check("rs_stall_req", 32'(imem_req), 32'h0);
        reset = 1'b1;
        settle();
        check("rs_pc_in", 32'(pc_in), 32'h0);
        check("rs_req", 32'(imem_req), 32'h0);
        cyc();
        check("rs_valid", 32'(instr_valid), 32'h0);
        check("rs_pc_out", 32'(pc_out), 32'h0);
        reset = 1'b0; instr_ready = 1'b1;
        settle();
        cyc();
        check("rs_first_pc", 32'(instr_pc), 32'h0);
        check("rs_first_instr", 32'(instr), 32'h100);
        cyc();
        check("rs_second_pc", 32'(instr_pc), 32'h1);

        // Redirect while stalled
        reset_dut(1'b0, 0);
        cyc(); cyc();
        redirect = 1'b1; redirect_target = 10'h080;
        settle();
        check("rst_stall_pc_in", 32'(pc_in), 32'h080);
        cyc();
        redirect = 1'b0;
        settle();
        check("rds_valid", 32'(instr_valid), 32'h0);
        check("rds_req", 32'(imem_req), 32'h1);
        check("rds_addr", 32'(imem_addr), 32'h080);
        cyc();
        check("rds_pc", 32'(instr_pc), 32'h080);
        check("rds_instr", 32'(instr), 32'h180);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
